function_unit_pipe: RTL and testbench

//  Parametrised, registered successor to the combinational function unit: same
//  4-bit fs op set, generalised to WIDTH bits, with valid/ready handshakes on

---
 rtl/function_unit_pipe.sv | 165 ++++++++++++++++
 tb/tb_function_unit_pipe.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/function_unit_pipe.sv
// Registered, handshaked function unit: single-cycle ALU/shift ops and an
// iterative shift-add multiply. The result and flags stay held until the consumer takes them.
module function_unit_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       fs,
  input  logic [SHW-1:0]   sh,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] fout,
  output logic             overflow,
  output logic             carryout,
  output logic             negative,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  localparam logic [SHW-1:0] LAST_BIT = SHW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] fout_q, fout_d;
  logic             ovf_q, ovf_d;
  logic             cry_q, cry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0] op2;
  logic             cin;
  logic             arith;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             res_ovf;
  logic             res_cry;
  logic [WIDTH-1:0] acc_nxt;
  logic             start;

  // Single-cycle result and flags for the op currently presented
  always_comb begin
    op2   = '0;
    cin   = 1'b0;
    arith = 1'b0;
    res   = '0;
    unique case (fs)
      4'b0000: arith = 1'b1;
      4'b0001: begin arith = 1'b1; cin = 1'b1; end
      4'b0010: begin arith = 1'b1; op2 = b; end
      4'b0011: begin arith = 1'b1; op2 = b; cin = 1'b1; end
      4'b0100: begin arith = 1'b1; op2 = ~b; end
      4'b0101: begin arith = 1'b1; op2 = ~b; cin = 1'b1; end
      4'b0110: begin arith = 1'b1; op2 = '1; end
      4'b0111: res = $signed(a) >>> sh;
      4'b1000: res = a & b;
      4'b1001: res = a | b;
      4'b1010: res = a ^ b;
      4'b1011: res = ~a;
      4'b1100: res = b;
      4'b1101: res = a << sh;
      4'b1110: res = a >> sh;
      4'b1111: res = '0;
    endcase
    sum = {1'b0, a} + {1'b0, op2} + {{WIDTH{1'b0}}, cin};
    if (arith) res = sum[WIDTH-1:0];
    res_cry = arith & sum[WIDTH];
    res_ovf = arith & (a[WIDTH-1] == op2[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
  end

  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Handshake FSM: next state, datapath register loads and handshake outputs
  always_comb begin
    state_d   = state_q;
    fout_d    = fout_q;
    ovf_d     = ovf_q;
    cry_d     = cry_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    start     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        start    = in_valid;
      end
      MUL: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        // The last step writes the finished sum straight into fout. This saves a cycle, so the multiply latency is WIDTH+1.
        if (cnt_q == LAST_BIT) begin
          fout_d  = acc_nxt;
          ovf_d   = 1'b0;
          cry_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) start = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      if (fs == 4'b1111) begin
        mcand_d  = a;
        mplier_d = b;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = MUL;
      end else begin
        fout_d  = res;
        ovf_d   = res_ovf;
        cry_d   = res_cry;
        state_d = DONE;
      end
    end
  end

  // State and datapath registers; reset drops any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      fout_q   <= '0;
      ovf_q    <= 1'b0;
      cry_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      fout_q   <= fout_d;
      ovf_q    <= ovf_d;
      cry_q    <= cry_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fout     = fout_q;
  assign overflow = ovf_q;
  assign carryout = cry_q;
  assign negative = fout_q[WIDTH-1];
  assign zero     = (fout_q == '0);

endmodule

// File: tb/tb_function_unit_pipe.sv
// Scoreboard bench for function_unit_pipe at WIDTH=32.
module tb_function_unit_pipe;
  localparam int unsigned W  = 32;
  localparam int unsigned SW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [3:0]    fs;
  logic [SW-1:0] sh;
  logic [W-1:0]  a, b, fout;
  logic          overflow, carryout, negative, zero;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] f;
    logic        ovf;
    logic        cry;
  } exp_t;

  typedef struct packed {
    logic [3:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  s;
    exp_t        e;
  } op_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  function_unit_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fs(fs), .sh(sh), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .fout(fout), .overflow(overflow), .carryout(carryout),
    .negative(negative), .zero(zero)
  );

  // Reference model: wide unsigned/signed arithmetic and the plain operators
  function automatic exp_t model(input logic [3:0] f, input logic [31:0] x,
                                 input logic [31:0] y, input logic [4:0] s);
    exp_t        r;
    logic [31:0] op2;
    logic        cin;
    logic [63:0] us;
    longint      ss;
    r = '0; op2 = '0; cin = 1'b0;
    case (f)
      4'd0: op2 = 32'h0;
      4'd1: begin op2 = 32'h0; cin = 1'b1; end
      4'd2: op2 = y;
      4'd3: begin op2 = y; cin = 1'b1; end
      4'd4: op2 = ~y;
      4'd5: begin op2 = ~y; cin = 1'b1; end
      4'd6: op2 = 32'hFFFF_FFFF;
      4'd7: r.f = (x >> s) | (x[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      4'd8: r.f = x & y;
      4'd9: r.f = x | y;
      4'd10: r.f = x ^ y;
      4'd11: r.f = ~x;
      4'd12: r.f = y;
      4'd13: r.f = x << s;
      4'd14: r.f = x >> s;
      default: r.f = x * y;
    endcase
    if (f <= 4'd6) begin
      us    = {32'h0, x} + {32'h0, op2} + {63'h0, cin};
      r.f   = us[31:0];
      r.cry = us[32];
      ss    = longint'($signed(x)) + longint'($signed(op2)) + longint'(cin);
      r.ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    end
    return r;
  endfunction

  // Drives one op, pushes its expectation, and returns after the accepting edge
  task automatic issue(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] s, input exp_t e, output bit ok);
    in_valid = 1'b1; fs = f; a = x; b = y; sh = s;
    sb.push_back(e);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready, fout, overflow, carryout, negative, zero} !==
        {1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: ov=%b ir=%b fout=%h flags=%b%b%b%b required ov=0 ir=1 fout=0 flags=0001",
               out_valid, in_ready, fout, overflow, carryout, negative, zero);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  op_t arith_v[13] = '{
    '{4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0, '{32'h8000_0000, 1'b1, 1'b0}},
    '{4'b0101, 32'h5, 32'h5, 5'd0, '{32'h0, 1'b0, 1'b1}},
    '{4'b0101, 32'h0, 32'h1, 5'd0, '{32'hFFFF_FFFF, 1'b0, 1'b0}},
    '{4'b0001, 32'hFFFF_FFFF, 32'h7, 5'd0, '{32'h0, 1'b0, 1'b1}},
    '{4'b0110, 32'h8000_0000, 32'h0, 5'd0, '{32'h7FFF_FFFF, 1'b1, 1'b1}},
    '{4'b0011, 32'h1, 32'h2, 5'd0, '{32'h4, 1'b0, 1'b0}},
    '{4'b0100, 32'h5, 32'h3, 5'd0, '{32'h1, 1'b0, 1'b1}},
    '{4'b0000, 32'h8000_0000, 32'h1234, 5'd0, '{32'h8000_0000, 1'b0, 1'b0}},
    '{4'b1000, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, '{32'h0000_F000, 1'b0, 1'b0}},
    '{4'b1001, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, '{32'h0000_FFF0, 1'b0, 1'b0}},
    '{4'b1010, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, '{32'h0000_0FF0, 1'b0, 1'b0}},
    '{4'b1011, 32'h0, 32'h5, 5'd0, '{32'hFFFF_FFFF, 1'b0, 1'b0}},
    '{4'b1100, 32'hAAAA_AAAA, 32'h1234, 5'd0, '{32'h1234, 1'b0, 1'b0}}
  };

  op_t shift_v[6] = '{
    '{4'b0111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, '{32'hF800_0000, 1'b0, 1'b0}},
    '{4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, '{32'h0800_0000, 1'b0, 1'b0}},
    '{4'b1101, 32'hDEAD_BEEF, 32'h1, 5'd0, '{32'hDEAD_BEEF, 1'b0, 1'b0}},
    '{4'b0111, 32'h4000_0000, 32'h0, 5'd31, '{32'h0, 1'b0, 1'b0}},
    '{4'b1101, 32'h1, 32'h0, 5'd31, '{32'h8000_0000, 1'b0, 1'b0}},
    '{4'b0111, 32'hF000_0000, 32'h0, 5'd0, '{32'hF000_0000, 1'b0, 1'b0}}
  };

  op_t mul_v[3] = '{
    '{4'b1111, 32'h0001_2345, 32'h0000_1000, 5'd3, '{32'h1234_5000, 1'b0, 1'b0}},
    '{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, '{32'h0000_0001, 1'b0, 1'b0}},
    '{4'b1111, 32'h0, 32'hDEAD_BEEF, 5'd0, '{32'h0, 1'b0, 1'b0}}
  };

  task automatic test_arith_logic;
    bit ok, got; exp_t e;
    for (int unsigned k = 0; k < 13; k++) begin
      issue(arith_v[k].f, arith_v[k].x, arith_v[k].y, arith_v[k].s, arith_v[k].e, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL arith_accept[%0d]: in_ready never 1, required 1", k); end
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (out_valid) begin got = 1'b1; break; end
      end
      checks++;
      if (!got || sb.size() == 0) begin
        errors++; $display("FAIL arith_valid[%0d]: out_valid=0 required 1", k);
      end else begin
        e = sb.pop_front();
        if ({fout, overflow, carryout, negative, zero} !== {e.f, e.ovf, e.cry, e.f[31], e.f == 32'h0}) begin
          errors++;
          $display("FAIL arith[%0d] fs=%b: fout=%h v=%b c=%b n=%b z=%b required fout=%h v=%b c=%b n=%b z=%b",
                   k, arith_v[k].f, fout, overflow, carryout, negative, zero,
                   e.f, e.ovf, e.cry, e.f[31], e.f == 32'h0);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_shift;
    bit ok, got; exp_t e;
    for (int unsigned k = 0; k < 6; k++) begin
      issue(shift_v[k].f, shift_v[k].x, shift_v[k].y, shift_v[k].s, shift_v[k].e, ok);
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (out_valid) begin got = 1'b1; break; end
      end
      checks++;
      if (!ok || !got || sb.size() == 0) begin
        errors++; $display("FAIL shift_handshake[%0d]: accept=%b valid=%b required 1 1", k, ok, got);
      end else begin
        e = sb.pop_front();
        if ({fout, overflow, carryout, negative, zero} !== {e.f, e.ovf, e.cry, e.f[31], e.f == 32'h0}) begin
          errors++;
          $display("FAIL shift[%0d] fs=%b sh=%0d: fout=%h flags=%b%b%b%b required fout=%h",
                   k, shift_v[k].f, shift_v[k].s, fout, overflow, carryout, negative, zero, e.f);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul;
    bit ok; exp_t e; int waitc; int busy_bad;
    for (int unsigned k = 0; k < 3; k++) begin
      issue(mul_v[k].f, mul_v[k].x, mul_v[k].y, mul_v[k].s, mul_v[k].e, ok);
      waitc = 0; busy_bad = 0;
      while (waitc < 200) begin
        @(negedge clk);
        if (out_valid) break;
        if (in_ready !== 1'b0) busy_bad++;
        waitc++;
      end
      checks++;
      if (!ok || waitc != 32) begin
        errors++; $display("FAIL mul_latency[%0d]: busy cycles=%0d required 32", k, waitc);
      end
      checks++;
      if (busy_bad != 0) begin
        errors++; $display("FAIL mul_in_ready[%0d]: in_ready high %0d busy cycles, required 0", k, busy_bad);
      end
      checks++;
      if (!out_valid || sb.size() == 0) begin
        errors++; $display("FAIL mul_valid[%0d]: out_valid=%b required 1", k, out_valid);
      end else begin
        e = sb.pop_front();
        if ({fout, overflow, carryout, negative, zero} !== {e.f, e.ovf, e.cry, e.f[31], e.f == 32'h0}) begin
          errors++;
          $display("FAIL mul[%0d]: fout=%h v=%b c=%b required fout=%h v=0 c=0", k, fout, overflow, carryout, e.f);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    bit ok; exp_t e; logic [35:0] held; int bad;
    out_ready = 1'b0;
    issue(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0, '{32'h8000_0000, 1'b1, 1'b0}, ok);
    @(negedge clk);
    held = {fout, overflow, carryout, negative, zero};
    checks++;
    if (!ok || !out_valid || held !== {32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL hold_first: valid=%b out=%h required valid=1 out=%h",
                         out_valid, held, {32'h8000_0000, 4'b1010});
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || {fout, overflow, carryout, negative, zero} !== held) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL hold_stable: %0d cycles changed or in_ready=1, required 0", bad);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; fs = 4'b1000; a = 32'hFF00_FF00; b = 32'h0F0F_0F0F;
    sb.push_back('{32'h0F00_0F00, 1'b0, 1'b0});
    @(negedge clk);
    checks++;
    if (!(out_valid === 1'b1 && in_ready === 1'b1)) begin
      errors++; $display("FAIL b2b_ready: out_valid=%b in_ready=%b required 1 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (sb.size() != 0) e = sb.pop_front();
    @(negedge clk);
    checks++;
    if (!out_valid || sb.size() == 0) begin
      errors++; $display("FAIL b2b_bubble: out_valid=%b required 1", out_valid);
    end else begin
      e = sb.pop_front();
      if ({fout, overflow, carryout, negative, zero} !== {e.f, e.ovf, e.cry, e.f[31], e.f == 32'h0}) begin
        errors++; $display("FAIL b2b_result: fout=%h required %h", fout, e.f);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul;
    bit ok, got; exp_t e; int spurious;
    issue(4'b1111, 32'h3, 32'h5, 5'd0, '{32'hF, 1'b0, 1'b0}, ok);
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if ({out_valid, fout, overflow, carryout, negative, zero} !== {1'b0, 32'h0, 4'b0001}) begin
      errors++; $display("FAIL reset_mid_mul: ov=%b fout=%h flags=%b%b%b%b required ov=0 fout=0 flags=0001",
                         out_valid, fout, overflow, carryout, negative, zero);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    issue(4'b0010, 32'd10, 32'd20, 5'd0, '{32'd30, 1'b0, 1'b0}, ok);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1'b1; break; end
    end
    checks++;
    if (!ok || !got || sb.size() == 0) begin
      errors++; $display("FAIL post_reset_op: valid=%b required 1", got);
    end else begin
      e = sb.pop_front();
      if ({fout, overflow, carryout, negative, zero} !== {e.f, e.ovf, e.cry, e.f[31], e.f == 32'h0}) begin
        errors++; $display("FAIL post_reset_result: fout=%h required %h", fout, e.f);
      end
    end
    @(posedge clk); #1;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++; $display("FAIL dropped_mul: out_valid high %0d cycles, required 0", spurious);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    bit ok, got; exp_t e; logic [3:0] f; logic [31:0] x, y; logic [4:0] s;
    for (int k = 0; k < 24; k++) begin
      f = 4'($urandom_range(0, 15));
      x = $urandom; y = $urandom; s = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) x = 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) y = 32'h8000_0000;
      issue(f, x, y, s, model(f, x, y, s), ok);
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (out_valid) begin got = 1'b1; break; end
      end
      checks++;
      if (!ok || !got || sb.size() == 0) begin
        errors++; $display("FAIL random_handshake[%0d]: accept=%b valid=%b required 1 1", k, ok, got);
      end else begin
        e = sb.pop_front();
        if ({fout, overflow, carryout, negative, zero} !== {e.f, e.ovf, e.cry, e.f[31], e.f == 32'h0}) begin
          errors++;
          $display("FAIL random[%0d] fs=%b a=%h b=%h sh=%0d: fout=%h v=%b c=%b required fout=%h v=%b c=%b",
                   k, f, x, y, s, fout, overflow, carryout, e.f, e.ovf, e.cry);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fs = '0; sh = '0; a = '0; b = '0;
    test_reset();
    test_arith_logic();
    test_shift();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
